// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer_pkg
// Description : Opcode constants, step-state enum, instruction-class enum and
//               the datapath strobe bundle shared by the control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package control_sequencer_pkg;

  // Opcode field values, ir[31:27]
  localparam logic [4:0] c_op_ld   = 5'd0;
  localparam logic [4:0] c_op_ldi  = 5'd1;
  localparam logic [4:0] c_op_st   = 5'd2;
  localparam logic [4:0] c_op_add  = 5'd3;
  localparam logic [4:0] c_op_sub  = 5'd4;
  localparam logic [4:0] c_op_and  = 5'd5;
  localparam logic [4:0] c_op_or   = 5'd6;
  localparam logic [4:0] c_op_shr  = 5'd7;
  localparam logic [4:0] c_op_shl  = 5'd8;
  localparam logic [4:0] c_op_ror  = 5'd9;
  localparam logic [4:0] c_op_rol  = 5'd10;
  localparam logic [4:0] c_op_addi = 5'd11;
  localparam logic [4:0] c_op_andi = 5'd12;
  localparam logic [4:0] c_op_ori  = 5'd13;
  localparam logic [4:0] c_op_mul  = 5'd14;
  localparam logic [4:0] c_op_div  = 5'd15;
  localparam logic [4:0] c_op_neg  = 5'd16;
  localparam logic [4:0] c_op_not  = 5'd17;
  localparam logic [4:0] c_op_br   = 5'd18;
  localparam logic [4:0] c_op_jr   = 5'd19;
  localparam logic [4:0] c_op_jal  = 5'd20;
  localparam logic [4:0] c_op_in   = 5'd21;
  localparam logic [4:0] c_op_out  = 5'd22;
  localparam logic [4:0] c_op_mfhi = 5'd23;
  localparam logic [4:0] c_op_mflo = 5'd24;
  localparam logic [4:0] c_op_nop  = 5'd25;
  localparam logic [4:0] c_op_halt = 5'd26;

  // Sequencer states: RESET, step counter T0..T9, HALT
  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_T8    = 4'd9,
    S_T9    = 4'd10,
    S_HALT  = 4'd11
  } state_e;

  // Instruction classes sharing one execute sequence
  typedef enum logic [4:0] {
    CL_ALU     = 5'd0,   // add sub and or shr shl ror rol
    CL_ALUI    = 5'd1,   // addi andi ori
    CL_LDI     = 5'd2,
    CL_LD      = 5'd3,
    CL_ST      = 5'd4,
    CL_UNARY   = 5'd5,   // neg not
    CL_MULDIV  = 5'd6,   // mul div
    CL_BR      = 5'd7,
    CL_JR      = 5'd8,
    CL_JAL     = 5'd9,
    CL_MFHI    = 5'd10,
    CL_MFLO    = 5'd11,
    CL_IN      = 5'd12,
    CL_OUT     = 5'd13,
    CL_NOP     = 5'd14,
    CL_HALT    = 5'd15,
    CL_ILLEGAL = 5'd16
  } op_class_e;

  // Datapath strobe bundle; cleared as a whole to give all-low defaults
  typedef struct packed {
    logic PCout;
    logic PCin;
    logic IncPC;
    logic MARin;
    logic MDRin;
    logic MDRout;
    logic Read;
    logic RAM_write_en;
    logic IRin;
    logic Yin;
    logic ZLowIn;
    logic ZHighIn;
    logic ZLowout;
    logic ZHighout;
    logic HIin;
    logic LOin;
    logic HIout;
    logic LOout;
    logic GRA;
    logic GRB;
    logic GRC;
    logic R_in;
    logic R_out;
    logic Baout;
    logic Cout;
    logic enableCon;
    logic InPortout;
    logic enableOutputPort;
    logic R15in;
  } strobes_t;

endpackage
`default_nettype wire

// File: rtl/op_class_decode.sv
`default_nettype none
// ============================================================================
// Module      : op_class_decode
// Description : Maps a 5-bit opcode onto the execute-sequence class it uses.
//               Unassigned opcodes map to CL_ILLEGAL.
// Revision    : 1.0 - initial release
// ============================================================================
module op_class_decode
  import control_sequencer_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class
);

  // Pure table lookup from opcode to class
  always_comb begin
    op_class = CL_ILLEGAL;
    case (opcode)
      c_op_add, c_op_sub, c_op_and, c_op_or,
      c_op_shr, c_op_shl, c_op_ror, c_op_rol: op_class = CL_ALU;
      c_op_addi, c_op_andi, c_op_ori:         op_class = CL_ALUI;
      c_op_ldi:                               op_class = CL_LDI;
      c_op_ld:                                op_class = CL_LD;
      c_op_st:                                op_class = CL_ST;
      c_op_neg, c_op_not:                     op_class = CL_UNARY;
      c_op_mul, c_op_div:                     op_class = CL_MULDIV;
      c_op_br:                                op_class = CL_BR;
      c_op_jr:                                op_class = CL_JR;
      c_op_jal:                               op_class = CL_JAL;
      c_op_mfhi:                              op_class = CL_MFHI;
      c_op_mflo:                              op_class = CL_MFLO;
      c_op_in:                                op_class = CL_IN;
      c_op_out:                               op_class = CL_OUT;
      c_op_nop:                               op_class = CL_NOP;
      c_op_halt:                              op_class = CL_HALT;
      default:                                op_class = CL_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hard-wired T-step control unit. Fetches in T0..T3, then runs
//               the opcode's execute sequence from T4 and returns to T0, or
//               parks in HALT. Outputs are a Moore decode of state and opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        stop,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        RAM_write_en,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        R_in,
  output logic        R_out,
  output logic        Baout,
  output logic        Cout,
  output logic        enableCon,
  output logic        InPortout,
  output logic        enableOutputPort,
  output logic        R15in,
  output logic        run,
  output logic        illegal
);

  state_e    r_state;
  state_e    w_next_state;
  op_class_e w_class;
  strobes_t  w_s;
  logic      w_last;
  logic      w_illegal;
  logic      w_unused_ir;

  // Only the opcode field steers sequencing; operand fields belong to the datapath
  assign w_unused_ir = ^ir[26:0];

  op_class_decode u_op_class_decode (
    .opcode   (ir[31:27]),
    .op_class (w_class)
  );

  // State register; clr low forces RESET immediately, which also kills all strobes
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_RESET;
    else      r_state <= w_next_state;
  end

  // Next-state and strobe decode; w_last marks the final step of an instruction
  always_comb begin
    w_next_state = r_state;
    w_s          = '0;
    w_last       = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_RESET: w_next_state = S_T0;
      S_T0: begin
        w_s.PCout = 1'b1; w_s.MARin = 1'b1; w_s.IncPC = 1'b1;
        w_next_state = S_T1;
      end
      S_T1: begin
        w_s.Read = 1'b1;
        w_next_state = S_T2;
      end
      S_T2: begin
        w_s.Read = 1'b1; w_s.MDRin = 1'b1;
        w_next_state = S_T3;
      end
      S_T3: begin
        w_s.MDRout = 1'b1; w_s.IRin = 1'b1;
        w_next_state = S_T4;
      end
      S_T4: begin
        w_next_state = S_T5;
        case (w_class)
          CL_ALU, CL_ALUI: begin
            w_s.GRB = 1'b1; w_s.R_out = 1'b1; w_s.Yin = 1'b1;
          end
          CL_LDI, CL_LD, CL_ST: begin
            w_s.GRB = 1'b1; w_s.R_out = 1'b1; w_s.Baout = 1'b1; w_s.Yin = 1'b1;
          end
          CL_UNARY: begin
            w_s.GRB = 1'b1; w_s.R_out = 1'b1; w_s.ZLowIn = 1'b1;
          end
          CL_MULDIV: begin
            w_s.GRA = 1'b1; w_s.R_out = 1'b1; w_s.Yin = 1'b1;
          end
          CL_BR: begin
            w_s.GRA = 1'b1; w_s.R_out = 1'b1; w_s.enableCon = 1'b1;
          end
          CL_JR: begin
            w_s.GRA = 1'b1; w_s.R_out = 1'b1; w_s.PCin = 1'b1; w_last = 1'b1;
          end
          CL_JAL: begin
            w_s.PCout = 1'b1; w_s.R15in = 1'b1;
          end
          CL_MFHI: begin
            w_s.HIout = 1'b1; w_s.GRA = 1'b1; w_s.R_in = 1'b1; w_last = 1'b1;
          end
          CL_MFLO: begin
            w_s.LOout = 1'b1; w_s.GRA = 1'b1; w_s.R_in = 1'b1; w_last = 1'b1;
          end
          CL_IN: begin
            w_s.InPortout = 1'b1; w_s.GRA = 1'b1; w_s.R_in = 1'b1; w_last = 1'b1;
          end
          CL_OUT: begin
            w_s.GRA = 1'b1; w_s.R_out = 1'b1; w_s.enableOutputPort = 1'b1;
            w_last = 1'b1;
          end
          CL_HALT:    w_next_state = S_HALT;
          CL_ILLEGAL: begin
            w_illegal = 1'b1; w_last = 1'b1;
          end
          default:    w_last = 1'b1;
        endcase
      end
      S_T5: begin
        w_next_state = S_T6;
        case (w_class)
          CL_ALU: begin
            w_s.GRC = 1'b1; w_s.R_out = 1'b1; w_s.ZLowIn = 1'b1;
          end
          CL_ALUI, CL_LDI, CL_LD, CL_ST: begin
            w_s.Cout = 1'b1; w_s.ZLowIn = 1'b1;
          end
          CL_UNARY: begin
            w_s.ZLowout = 1'b1; w_s.GRA = 1'b1; w_s.R_in = 1'b1; w_last = 1'b1;
          end
          CL_MULDIV: begin
            w_s.GRB = 1'b1; w_s.R_out = 1'b1; w_s.ZLowIn = 1'b1; w_s.ZHighIn = 1'b1;
          end
          CL_BR: begin
            w_s.PCout = 1'b1; w_s.Yin = 1'b1;
          end
          CL_JAL: begin
            w_s.GRA = 1'b1; w_s.R_out = 1'b1; w_s.PCin = 1'b1; w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      S_T6: begin
        w_next_state = S_T7;
        case (w_class)
          CL_ALU, CL_ALUI, CL_LDI: begin
            w_s.ZLowout = 1'b1; w_s.GRA = 1'b1; w_s.R_in = 1'b1; w_last = 1'b1;
          end
          CL_LD, CL_ST: begin
            w_s.ZLowout = 1'b1; w_s.MARin = 1'b1;
          end
          CL_MULDIV: begin
            w_s.ZLowout = 1'b1; w_s.LOin = 1'b1;
          end
          CL_BR: begin
            w_s.Cout = 1'b1; w_s.ZLowIn = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      S_T7: begin
        w_next_state = S_T8;
        case (w_class)
          CL_LD: w_s.Read = 1'b1;
          CL_ST: begin
            w_s.GRA = 1'b1; w_s.R_out = 1'b1; w_s.MDRin = 1'b1;
          end
          CL_MULDIV: begin
            w_s.ZHighout = 1'b1; w_s.HIin = 1'b1; w_last = 1'b1;
          end
          CL_BR: begin
            // Branch target only committed when the condition flip-flop is set
            if (con_ff) begin
              w_s.ZLowout = 1'b1; w_s.PCin = 1'b1;
            end
            w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      S_T8: begin
        w_next_state = S_T9;
        case (w_class)
          CL_LD: begin
            w_s.Read = 1'b1; w_s.MDRin = 1'b1;
          end
          CL_ST: begin
            w_s.RAM_write_en = 1'b1; w_last = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      S_T9: begin
        if (w_class == CL_LD) begin
          w_s.MDRout = 1'b1; w_s.GRA = 1'b1; w_s.R_in = 1'b1;
        end
        w_last = 1'b1;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_RESET;
    endcase
    // Instruction boundary: honour a pending stop request
    if (w_last) w_next_state = stop ? S_HALT : S_T0;
  end

  assign run     = (r_state != S_RESET) && (r_state != S_HALT);
  assign illegal = w_illegal;

  assign PCout            = w_s.PCout;
  assign PCin             = w_s.PCin;
  assign IncPC            = w_s.IncPC;
  assign MARin            = w_s.MARin;
  assign MDRin            = w_s.MDRin;
  assign MDRout           = w_s.MDRout;
  assign Read             = w_s.Read;
  assign RAM_write_en     = w_s.RAM_write_en;
  assign IRin             = w_s.IRin;
  assign Yin              = w_s.Yin;
  assign ZLowIn           = w_s.ZLowIn;
  assign ZHighIn          = w_s.ZHighIn;
  assign ZLowout          = w_s.ZLowout;
  assign ZHighout         = w_s.ZHighout;
  assign HIin             = w_s.HIin;
  assign LOin             = w_s.LOin;
  assign HIout            = w_s.HIout;
  assign LOout            = w_s.LOout;
  assign GRA              = w_s.GRA;
  assign GRB              = w_s.GRB;
  assign GRC              = w_s.GRC;
  assign R_in             = w_s.R_in;
  assign R_out            = w_s.R_out;
  assign Baout            = w_s.Baout;
  assign Cout             = w_s.Cout;
  assign enableCon        = w_s.enableCon;
  assign InPortout        = w_s.InPortout;
  assign enableOutputPort = w_s.enableOutputPort;
  assign R15in            = w_s.R15in;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer. Each task
//               drives one scenario and compares the {run, illegal, strobes}
//               vector against hand-built expected vectors per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] ir  = 32'h0;
  logic        con_ff = 1'b0;
  logic        stop = 1'b0;

  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, RAM_write_en, IRin;
  logic Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout;
  logic GRA, GRB, GRC, R_in, R_out, Baout, Cout, enableCon, InPortout;
  logic enableOutputPort, R15in, run, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Bit positions inside the observed vector
  localparam logic [30:0] RUN    = 31'h1 << 30;
  localparam logic [30:0] ILL    = 31'h1 << 29;
  localparam logic [30:0] PCOUT  = 31'h1 << 28;
  localparam logic [30:0] PCIN   = 31'h1 << 27;
  localparam logic [30:0] INCPC  = 31'h1 << 26;
  localparam logic [30:0] MARIN  = 31'h1 << 25;
  localparam logic [30:0] MDRIN  = 31'h1 << 24;
  localparam logic [30:0] MDROUT = 31'h1 << 23;
  localparam logic [30:0] READ   = 31'h1 << 22;
  localparam logic [30:0] RAMWE  = 31'h1 << 21;
  localparam logic [30:0] IRIN   = 31'h1 << 20;
  localparam logic [30:0] YIN    = 31'h1 << 19;
  localparam logic [30:0] ZLIN   = 31'h1 << 18;
  localparam logic [30:0] ZHIN   = 31'h1 << 17;
  localparam logic [30:0] ZLOUT  = 31'h1 << 16;
  localparam logic [30:0] ZHOUT  = 31'h1 << 15;
  localparam logic [30:0] HIIN   = 31'h1 << 14;
  localparam logic [30:0] LOIN   = 31'h1 << 13;
  localparam logic [30:0] HIOUT  = 31'h1 << 12;
  localparam logic [30:0] LOOUT  = 31'h1 << 11;
  localparam logic [30:0] GRAB   = 31'h1 << 10;
  localparam logic [30:0] GRBB   = 31'h1 << 9;
  localparam logic [30:0] GRCB   = 31'h1 << 8;
  localparam logic [30:0] RIN    = 31'h1 << 7;
  localparam logic [30:0] ROUT   = 31'h1 << 6;
  localparam logic [30:0] BAOUT  = 31'h1 << 5;
  localparam logic [30:0] COUT   = 31'h1 << 4;
  localparam logic [30:0] ENCON  = 31'h1 << 3;
  localparam logic [30:0] INPO   = 31'h1 << 2;
  localparam logic [30:0] ENOUT  = 31'h1 << 1;
  localparam logic [30:0] R15IN  = 31'h1 << 0;

  localparam logic [30:0] F0 = RUN | PCOUT | MARIN | INCPC;
  localparam logic [30:0] F1 = RUN | READ;
  localparam logic [30:0] F2 = RUN | READ | MDRIN;
  localparam logic [30:0] F3 = RUN | MDROUT | IRIN;

  logic [30:0] obs;
  assign obs = {run, illegal, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read,
                RAM_write_en, IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout,
                HIin, LOin, HIout, LOout, GRA, GRB, GRC, R_in, R_out, Baout,
                Cout, enableCon, InPortout, enableOutputPort, R15in};

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .RAM_write_en(RAM_write_en), .IRin(IRin),
    .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .ZLowout(ZLowout),
    .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
    .LOout(LOout), .GRA(GRA), .GRB(GRB), .GRC(GRC), .R_in(R_in),
    .R_out(R_out), .Baout(Baout), .Cout(Cout), .enableCon(enableCon),
    .InPortout(InPortout), .enableOutputPort(enableOutputPort),
    .R15in(R15in), .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Stimulus only: reset pulse released on a falling edge; returns sampling T0
  task automatic pulse_reset();
    @(negedge clk); clr = 1'b0;
    @(negedge clk); clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); clr = 1'b0;
    #1;
    n_checks++;
    if (obs !== 31'h0) begin
      n_fail++; $display("FAIL reset_hold obs=%h exp=%h", obs, 31'h0);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== 31'h0) begin
      n_fail++; $display("FAIL reset_hold2 obs=%h exp=%h", obs, 31'h0);
    end
    clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== F0) begin
      n_fail++; $display("FAIL reset_release obs=%h exp=%h", obs, F0);
    end
  endtask

  task automatic test_add();
    logic [30:0] ev [8];
    ev = '{F0, F1, F2, F3, RUN|GRBB|ROUT|YIN, RUN|GRCB|ROUT|ZLIN,
           RUN|ZLOUT|GRAB|RIN, F0};
    ir = {5'd3, 27'h0012345};
    pulse_reset();
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs !== ev[k]) begin
        n_fail++; $display("FAIL add step%0d obs=%h exp=%h", k, obs, ev[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ld();
    logic [30:0] ev [11];
    ev = '{F0, F1, F2, F3, RUN|GRBB|ROUT|BAOUT|YIN, RUN|COUT|ZLIN,
           RUN|ZLOUT|MARIN, RUN|READ, RUN|READ|MDRIN, RUN|MDROUT|GRAB|RIN, F0};
    ir = {5'd0, 27'h1ABCDEF};
    pulse_reset();
    for (int k = 0; k < 11; k++) begin
      n_checks++;
      if (obs !== ev[k]) begin
        n_fail++; $display("FAIL ld step%0d obs=%h exp=%h", k, obs, ev[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_br();
    logic [30:0] ev0 [9];
    logic [30:0] ev1 [8];
    ev0 = '{F0, F1, F2, F3, RUN|GRAB|ROUT|ENCON, RUN|PCOUT|YIN,
            RUN|COUT|ZLIN, RUN, F0};
    ev1 = '{F1, F2, F3, RUN|GRAB|ROUT|ENCON, RUN|PCOUT|YIN,
            RUN|COUT|ZLIN, RUN|ZLOUT|PCIN, F0};
    ir = {5'd18, 27'h0000040};
    con_ff = 1'b0;
    pulse_reset();
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (obs !== ev0[k]) begin
        n_fail++; $display("FAIL br_nt step%0d obs=%h exp=%h", k, obs, ev0[k]);
      end
      if (k < 8) @(negedge clk);
    end
    // Back-to-back: second br continues from the T0 just checked
    con_ff = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (obs !== ev1[k]) begin
        n_fail++; $display("FAIL br_t step%0d obs=%h exp=%h", k + 1, obs, ev1[k]);
      end
      @(negedge clk);
    end
    con_ff = 1'b0;
  endtask

  task automatic test_st();
    logic [30:0] ev [10];
    ev = '{F0, F1, F2, F3, RUN|GRBB|ROUT|BAOUT|YIN, RUN|COUT|ZLIN,
           RUN|ZLOUT|MARIN, RUN|GRAB|ROUT|MDRIN, RUN|RAMWE, F0};
    ir = {5'd2, 27'h0001111};
    pulse_reset();
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (obs !== ev[k]) begin
        n_fail++; $display("FAIL st step%0d obs=%h exp=%h", k, obs, ev[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_jal();
    logic [30:0] ev [7];
    ev = '{F0, F1, F2, F3, RUN|PCOUT|R15IN, RUN|GRAB|ROUT|PCIN, F0};
    ir = {5'd20, 27'h0};
    pulse_reset();
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (obs !== ev[k]) begin
        n_fail++; $display("FAIL jal step%0d obs=%h exp=%h", k, obs, ev[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stop_mul();
    logic [30:0] ev [11];
    ev = '{F0, F1, F2, F3, RUN|GRAB|ROUT|YIN, RUN|GRBB|ROUT|ZLIN|ZHIN,
           RUN|ZLOUT|LOIN, RUN|ZHOUT|HIIN, 31'h0, 31'h0, 31'h0};
    ir = {5'd14, 27'h0};
    stop = 1'b0;
    pulse_reset();
    for (int k = 0; k < 11; k++) begin
      n_checks++;
      if (obs !== ev[k]) begin
        n_fail++; $display("FAIL mul_stop step%0d obs=%h exp=%h", k, obs, ev[k]);
      end
      if (k == 5) stop = 1'b1;
      if (k == 9) stop = 1'b0;
      @(negedge clk);
    end
    // HALT is left only through clr
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== F0) begin
      n_fail++; $display("FAIL halt_exit obs=%h exp=%h", obs, F0);
    end
  endtask

  task automatic test_halt_op();
    ir = {5'd26, 27'h0};
    pulse_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (obs !== RUN) begin
      n_fail++; $display("FAIL halt_op_t4 obs=%h exp=%h", obs, RUN);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== 31'h0) begin
      n_fail++; $display("FAIL halt_op_halt obs=%h exp=%h", obs, 31'h0);
    end
  endtask

  task automatic test_async_reset();
    ir = {5'd0, 27'h0};
    pulse_reset();
    repeat (7) @(negedge clk);
    n_checks++;
    if (obs !== (RUN|READ)) begin
      n_fail++; $display("FAIL ld_t7 obs=%h exp=%h", obs, RUN|READ);
    end
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if (obs !== 31'h0) begin
      n_fail++; $display("FAIL async_clr obs=%h exp=%h", obs, 31'h0);
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== F0) begin
      n_fail++; $display("FAIL async_clr_release obs=%h exp=%h", obs, F0);
    end
  endtask

  task automatic test_illegal();
    logic [30:0] ev [6];
    ev = '{F0, F1, F2, F3, RUN|ILL, F0};
    ir = {5'd31, 27'h7FFFFFF};
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (obs !== ev[k]) begin
        n_fail++; $display("FAIL illegal step%0d obs=%h exp=%h", k, obs, ev[k]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld();
    test_br();
    test_st();
    test_jal();
    test_stop_mul();
    test_halt_op();
    test_async_reset();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on the rising edge.
REQ-002 SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port ir, input, 32 bits: instruction register contents; ir[31:27] is the opcode.
REQ-004 SHALL have port con_ff, input, 1 bit: branch-condition flip-flop from the datapath.
REQ-005 SHALL have port stop, input, 1 bit: request to halt at the next instruction boundary.
REQ-006 SHALL have these outputs, 1 bit each, datapath strobes: PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, RAM_write_en, IRin, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout, GRA, GRB, GRC, R_in, R_out, Baout, Cout, enableCon, InPortout, enableOutputPort, R15in.
REQ-007 SHALL have port run, output, 1 bit: high while sequencing; low in RESET and HALT.
REQ-008 SHALL have port illegal, output, 1 bit: one-cycle pulse in step T4 for an undefined opcode.

Function
REQ-009 SHALL use the following states:
- RESET
- step counter T0..T9
- HALT
REQ-010 SHALL make all outputs a combinational (Moore) decode of the state and ir[31:27]; ir SHALL be sampled only in T4 and later.
REQ-011 SHALL run the fetch as:
- T0: PCout, MARin, IncPC
- T1: Read (RAM latency wait)
- T2: Read, MDRin
- T3: MDRout, IRin
REQ-012 SHALL sequence add, sub, and, or, shr, shl, ror, rol as:
- T4: GRB, R_out, Yin
- T5: GRC, R_out, ZLowIn
- T6: ZLowout, GRA, R_in
REQ-013 SHALL sequence addi, andi, ori as REQ-012, with T5 replaced by Cout, ZLowIn.
REQ-014 SHALL sequence ldi as:
- T4: GRB, R_out, Baout, Yin
- T5: Cout, ZLowIn
- T6: ZLowout, GRA, R_in
REQ-015 SHALL sequence ld as:
- T4–T5: as ldi
- T6: ZLowout, MARin
- T7: Read
- T8: Read, MDRin
- T9: MDRout, GRA, R_in
REQ-016 SHALL sequence st as:
- T4–T5: as ldi
- T6: ZLowout, MARin
- T7: GRA, R_out, MDRin, with Read low
- T8: RAM_write_en
REQ-017 SHALL sequence neg and not as:
- T4: GRB, R_out, ZLowIn
- T5: ZLowout, GRA, R_in
REQ-018 SHALL sequence mul and div as:
- T4: GRA, R_out, Yin
- T5: GRB, R_out, ZLowIn, ZHighIn
- T6: ZLowout, LOin
- T7: ZHighout, HIin
REQ-019 SHALL sequence br as:
- T4: GRA, R_out, enableCon
- T5: PCout, Yin
- T6: Cout, ZLowIn
- T7: ZLowout, PCin only if con_ff=1; otherwise no strobes
REQ-020 SHALL sequence jr as T4: GRA, R_out, PCin.
REQ-021 SHALL sequence jal as:
- T4: PCout, R15in
- T5: GRA, R_out, PCin
REQ-022 SHALL sequence the single-step opcodes, each in T4, as:
- mfhi: HIout, GRA, R_in
- mflo: LOout, GRA, R_in
- in: InPortout, GRA, R_in
- out: GRA, R_out, enableOutputPort
REQ-023 SHALL handle nop and undefined opcodes by completing in T4 with no strobes (undefined opcodes additionally pulse illegal); halt SHALL go from T4 to HALT.
REQ-024 SHALL, after the last step of each instruction, go to T0, or to HALT if stop=1 on that edge.
REQ-025 SHALL hold HALT, with all strobes low, until clr is asserted.
REQ-026 SHALL make at most one bus-driver strobe active per cycle (PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, R_out); RAM_write_en and MDRin SHALL never be high together.

Reset
REQ-027 SHALL, while clr=0, immediately force state RESET with every output 0, including run.
REQ-028 SHALL advance from RESET to T0 on the first rising edge after clr rises.
REQ-029 SHALL, if reset is asserted mid-instruction, abort the instruction with no further strobes; a pending RAM_write_en SHALL drop asynchronously.

Structure
REQ-030 SHALL take from a shared package: 5-bit opcode constants ld=0, ldi=1, st=2, add=3, sub=4, and=5, or=6, shr=7, shl=8, ror=9, rol=10, addi=11, andi=12, ori=13, mul=14, div=15, neg=16, not=17, br=18, jr=19, jal=20, in=21, out=22, mfhi=23, mflo=24, nop=25, halt=26; and the state enum.
REQ-031 SHALL contain one sub-module, op_class_decode (opcode to class), instantiated once.

Verification
REQ-032 SHALL cover: reset release then ir=add R3,R1,R2 -> T0 PCout+MARin+IncPC; T6 ZLowout+GRA+R_in; next cycle T0.
REQ-033 SHALL cover: ld (opcode 0) -> MARin in T0 and T6; MDRin in T2 and T8; R_in only in T9; 10 cycles total.
REQ-034 SHALL cover: br with con_ff=0 -> no PCin in T7; the same with con_ff=1 -> ZLowout+PCin in T7.
REQ-035 SHALL cover: st -> RAM_write_en high only in T8, with MDRin low in that cycle.
REQ-036 SHALL cover: stop=1 during mul T5 -> mul completes T7 (HIin), then HALT, run=0; clr pulse -> T0.
REQ-037 SHALL cover: clr low in ld T7 -> outputs 0 without waiting for a clock edge; opcode 31 -> illegal pulse in T4, then T0.
